// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   - cache_state_e : refill/flush controller states (IDLE=0, REFILL=1, FLUSH=2)
//   - ofs_w/idx_w/tag_w/wofs_w/cnt_w : address-split and counter widths
//     derived from the LINES and WORDS parameters of the cache.
package cache_pkg;

  localparam int DEF_LINES = 32;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } cache_state_e;

  // Byte-offset field width: 2 byte bits plus the word-within-line bits.
  function automatic int ofs_w(input int words);
    return 2 + $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 32 - ofs_w(words) - idx_w(lines);
  endfunction

  // Word-select width; kept at least 1 so single-word lines still get a port.
  function automatic int wofs_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Shared word/line counter must reach max(WORDS, LINES) - 1.
  function automatic int cnt_w(input int lines, input int words);
    return $clog2((lines > words) ? lines : words);
  endfunction

endpackage

// File: rtl/m_cache_array.sv
// Tag, data and valid storage for the direct-mapped cache.
//   clk, rst          : clock and synchronous active-high reset (clears valid only)
//   rd_idx, rd_ofs    : asynchronous lookup -> rd_valid, rd_tag, rd_data
//   wr_en/wr_idx/wr_ofs/wr_data : one data word written per cycle
//   tag_we/wr_tag     : writes the tag of line wr_idx and marks it valid
//   clr_en/clr_idx    : invalidates one line
module m_cache_array
  import cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  localparam int IDX_W  = idx_w(LINES),
  localparam int TAG_W  = tag_w(LINES, WORDS),
  localparam int WOFS_W = wofs_w(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WOFS_W-1:0] rd_ofs,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFS_W-1:0] wr_ofs,
  input  logic [31:0]       wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx
);

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];
  logic [LINES-1:0] valid_q, valid_d;

  // NOTE: tag and data arrays have no reset; the valid bit alone qualifies
  // their contents, which keeps them mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_idx][wr_ofs] <= wr_data;
    if (tag_we) tag_mem[wr_idx]          <= wr_tag;
  end

  // NOTE: every variable written in an always_comb gets its default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (clr_en) valid_d[clr_idx] = 1'b0;
    if (tag_we) valid_d[wr_idx]  = 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx][rd_ofs];

endmodule

// File: rtl/m_cache_refill.sv
// Direct-mapped read-only instruction cache with line refill and flush.
//   w_clk, w_rst      : clock, synchronous active-high reset
//   w_req, w_adr      : core read request (held until w_rdy)
//   w_rdy, w_dout     : same-cycle hit completion and read word
//   w_busy            : high while refilling or flushing
//   w_flush           : single-cycle request to invalidate every line
//   w_mreq, w_madr    : memory word request and word-aligned address
//   w_mack, w_mdata   : memory data return strobe and data
module m_cache_refill
  import cache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_req,
  input  logic [31:0] w_adr,
  output logic        w_rdy,
  output logic [31:0] w_dout,
  output logic        w_busy,
  input  logic        w_flush,
  output logic        w_mreq,
  output logic [31:0] w_madr,
  input  logic        w_mack,
  input  logic [31:0] w_mdata
);

  localparam int OFS_W  = ofs_w(WORDS);
  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(LINES, WORDS);
  localparam int WOFS_W = wofs_w(WORDS);
  localparam int CNT_W  = cnt_w(LINES, WORDS);

  cache_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      base_q, base_d;

  // Request address split.
  logic [WOFS_W-1:0] req_ofs;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  assign req_ofs = WOFS_W'((w_adr >> 2) & 32'(WORDS - 1));
  assign req_idx = IDX_W'(w_adr >> OFS_W);
  assign req_tag = TAG_W'(w_adr >> (OFS_W + IDX_W));

  // Line being refilled, recovered from the latched base address.
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign fill_idx = IDX_W'(base_q >> OFS_W);
  assign fill_tag = TAG_W'(base_q >> (OFS_W + IDX_W));

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic             rdy;
  logic             word_we;
  logic             fill_done;
  logic             clr_en;

  assign hit = rd_valid & (rd_tag == req_tag);

  m_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk      (w_clk),
    .rst      (w_rst),
    .rd_idx   (req_idx),
    .rd_ofs   (req_ofs),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (w_dout),
    .wr_en    (word_we),
    .wr_idx   (fill_idx),
    .wr_ofs   (WOFS_W'(cnt_q)),
    .wr_data  (w_mdata),
    .tag_we   (fill_done),
    .wr_tag   (fill_tag),
    .clr_en   (clr_en),
    .clr_idx  (IDX_W'(cnt_q))
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    base_d    = base_q;
    rdy       = 1'b0;
    w_mreq    = 1'b0;
    word_we   = 1'b0;
    fill_done = 1'b0;
    clr_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flush (new or deferred from a refill) wins over the request.
        if (w_flush || pend_q) begin
          state_d = FLUSH;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (w_req && hit) begin
          rdy = 1'b1;
        end else if (w_req) begin
          state_d = REFILL;
          cnt_d   = '0;
          base_d  = {req_tag, req_idx, {OFS_W{1'b0}}};
        end
      end

      REFILL: begin
        w_mreq = 1'b1;
        if (w_flush) pend_d = 1'b1;
        if (w_mack) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end
        end
      end

      FLUSH: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LINES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      base_q  <= base_d;
    end
  end

  // Counter is zero outside REFILL/FLUSH, so the address is zero after reset.
  assign w_madr = base_q + (32'(cnt_q) << 2);
  assign w_rdy  = rdy & ~w_rst;
  assign w_busy = (state_q != IDLE);

endmodule

// File: tb/tb_m_cache_refill.sv
module tb_m_cache_refill;

  localparam int LINES      = 32;
  localparam int WORDS      = 4;
  localparam int LINE_BYTES = WORDS * 4;

  logic        w_clk = 1'b0;
  logic        w_rst, w_req, w_flush, w_mack;
  logic [31:0] w_adr, w_mdata;
  logic        w_rdy, w_busy, w_mreq;
  logic [31:0] w_dout, w_madr;

  m_cache_refill #(.LINES(LINES), .WORDS(WORDS)) dut (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_req   (w_req),
    .w_adr   (w_adr),
    .w_rdy   (w_rdy),
    .w_dout  (w_dout),
    .w_busy  (w_busy),
    .w_flush (w_flush),
    .w_mreq  (w_mreq),
    .w_madr  (w_madr),
    .w_mack  (w_mack),
    .w_mdata (w_mdata)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s bound expired at %0t", name, $time);
  endtask

  // Backing memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- memory responder ----------------
  bit          rand_mode = 0;
  bit          spurious  = 0;
  int          wait_cnt  = 2;
  logic [31:0] ack_q[$];

  function automatic int next_delay();
    return rand_mode ? int'($urandom_range(0, 3)) : 2;
  endfunction

  always @(posedge w_clk) begin
    #1;
    if (w_mreq) begin
      if (wait_cnt == 0) begin
        w_mack  = 1'b1;
        w_mdata = mem_word(w_madr);
        ack_q.push_back(w_madr);
        wait_cnt = next_delay();
      end else begin
        w_mack  = 1'b0;
        wait_cnt--;
      end
    end else begin
      w_mack   = spurious && ($urandom_range(0, 7) == 0);
      w_mdata  = $urandom;
      wait_cnt = next_delay();
    end
  end

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FILL, M_FLUSH} mode_e;
  mode_e       m_mode = M_IDLE;
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_fill_adr;
  int          m_got, m_flush_left;
  bit          m_pend, model_live = 0;
  bit          seen_rdy = 0;
  bit          e_busy, e_mreq, e_rdy;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  function automatic bit line_hit(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
  endfunction

  always @(negedge w_clk) begin
    if (model_live) begin
      e_busy = (m_mode != M_IDLE);
      e_mreq = (m_mode == M_FILL);
      e_rdy  = !w_rst && (m_mode == M_IDLE) && !(w_flush || m_pend) && w_req && line_hit(w_adr);
      check("busy", w_busy, e_busy);
      check("mreq", w_mreq, e_mreq);
      check("rdy", w_rdy, e_rdy);
      if (e_mreq) check("madr", w_madr, m_fill_adr + 32'(4 * m_got));
      if (e_rdy)  check("dout", w_dout, mem_word(w_adr));
    end
    seen_rdy = w_rdy;

    // Advance the model to the state after the coming rising edge.
    if (w_rst) begin
      m_mode = M_IDLE;
      m_pend = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
      model_live = 1;
    end else if (model_live) begin
      case (m_mode)
        M_IDLE: begin
          if (w_flush || m_pend) begin
            m_mode = M_FLUSH;
            m_flush_left = LINES;
            m_pend = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
          end else if (w_req && !line_hit(w_adr)) begin
            m_mode = M_FILL;
            m_got = 0;
            m_fill_adr = w_adr - (w_adr % LINE_BYTES);
          end
        end
        M_FILL: begin
          if (w_flush) m_pend = 1;
          if (w_mack) begin
            m_got++;
            if (m_got == WORDS) begin
              m_valid[line_of(m_fill_adr)] = 1;
              m_tag[line_of(m_fill_adr)]   = tag_of(m_fill_adr);
              m_mode = M_IDLE;
            end
          end
        end
        M_FLUSH: begin
          m_flush_left--;
          if (m_flush_left == 0) m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  // Issues a request and holds it until w_rdy; cyc counts the stalled cycles.
  task automatic access(input logic [31:0] a, output int cyc, output logic [31:0] dout);
    w_req = 1'b1;
    w_adr = a;
    cyc   = 0;
    dout  = '0;
    while (1) begin
      @(negedge w_clk);
      if (w_rdy) begin
        dout = w_dout;
        break;
      end
      cyc++;
      if (cyc > 300) begin
        fail_now("access_wait");
        break;
      end
      @(posedge w_clk); #1;
    end
    @(posedge w_clk); #1;
    w_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 4)
      | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, fc, rdy_cnt, n, qs;
    logic [31:0] d;

    w_rst = 1'b1; w_req = 1'b0; w_adr = 32'h1234; w_flush = 1'b0;
    w_mack = 1'b0; w_mdata = '0;

    // Reset
    repeat (3) @(posedge w_clk);
    #1 w_req = 1'b1;
    @(negedge w_clk);
    check("rst_busy", w_busy, 0);
    check("rst_mreq", w_mreq, 0);
    check("rst_rdy", w_rdy, 0);
    @(posedge w_clk); #1;
    w_rst = 1'b0; w_req = 1'b0;
    @(negedge w_clk);
    check("rst_madr", w_madr, 32'h0);
    @(posedge w_clk); #1;

    // Cold miss
    ack_q.delete();
    access(32'h0000_1234, cyc, d);
    check("cold_latency", cyc, 13);
    check("cold_dout", d, mem_word(32'h0000_1234));
    qs = ack_q.size();
    check("cold_nacks", qs, 4);
    if (qs == 4) begin
      check("cold_madr0", ack_q[0], 32'h1230);
      check("cold_madr1", ack_q[1], 32'h1234);
      check("cold_madr2", ack_q[2], 32'h1238);
      check("cold_madr3", ack_q[3], 32'h123C);
    end

    // Hit after fill
    w_req = 1'b1; w_adr = 32'h0000_1238;
    @(negedge w_clk);
    check("hit_rdy", w_rdy, 1);
    check("hit_dout", w_dout, mem_word(32'h0000_1238));
    check("hit_mreq", w_mreq, 0);
    @(posedge w_clk); #1;
    w_req = 1'b0;

    // Conflict miss, then the evicted line misses again
    ack_q.delete();
    access(32'h0000_1430, cyc, d);
    check("conf_latency", cyc, 13);
    qs = ack_q.size();
    check("conf_nacks", qs, 4);
    if (qs == 4) begin
      check("conf_madr0", ack_q[0], 32'h1430);
      check("conf_madr3", ack_q[3], 32'h143C);
    end
    access(32'h0000_1234, cyc, d);
    check("evict_latency", cyc, 13);

    // Flush in IDLE with a hitting request held alongside
    w_flush = 1'b1; w_req = 1'b1; w_adr = 32'h0000_1238;
    @(negedge w_clk);
    check("flush_prio_rdy", w_rdy, 0);
    @(posedge w_clk); #1;
    w_flush = 1'b0;
    fc = 0; rdy_cnt = 0;
    while (1) begin
      @(negedge w_clk);
      if (!w_busy) break;
      fc++;
      if (w_rdy) rdy_cnt++;
      if (fc > 100) begin
        fail_now("flush_wait");
        break;
      end
      @(posedge w_clk); #1;
    end
    check("flush_len", fc, LINES);
    check("flush_rdy", rdy_cnt, 0);
    check("flush_then_miss", w_rdy, 0);
    @(posedge w_clk); #1;
    access(32'h0000_1238, cyc, d);
    check("post_flush_fill", cyc, 12);

    // Flush during refill
    ack_q.delete();
    w_req = 1'b1; w_adr = 32'h0000_1434;
    n = 0;
    while (ack_q.size() < 2 && n < 100) begin
      @(posedge w_clk); #2;
      n++;
    end
    if (ack_q.size() < 2) fail_now("fir_ack_wait");
    @(posedge w_clk); #1;
    w_flush = 1'b1;
    @(posedge w_clk); #1;
    w_flush = 1'b0;
    fc = 0; n = 0; rdy_cnt = 0;
    while (n < 400) begin
      @(negedge w_clk);
      if (w_rdy) begin
        rdy_cnt = 1;
        break;
      end
      if (w_busy && !w_mreq) fc++;
      n++;
      @(posedge w_clk); #1;
    end
    if (rdy_cnt == 0) fail_now("fir_rdy_wait");
    check("fir_flush_len", fc, LINES);
    qs = ack_q.size();
    check("fir_nacks", qs, 8);
    if (qs == 8) begin
      check("fir_first", ack_q[0], 32'h1430);
      check("fir_refetch", ack_q[4], 32'h1430);
    end
    @(posedge w_clk); #1;
    w_req = 1'b0;

    // Reset in the middle of a refill
    ack_q.delete();
    w_req = 1'b1; w_adr = 32'h0000_1234;
    n = 0;
    while (ack_q.size() < 1 && n < 100) begin
      @(posedge w_clk); #2;
      n++;
    end
    if (ack_q.size() < 1) fail_now("rmr_ack_wait");
    @(posedge w_clk); #1;
    w_rst = 1'b1;
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    @(negedge w_clk);
    check("rmr_mreq", w_mreq, 0);
    check("rmr_busy", w_busy, 0);
    check("rmr_rdy", w_rdy, 0);
    ack_q.delete();
    @(posedge w_clk); #1;
    access(32'h0000_1234, cyc, d);
    check("rmr_refill", cyc, 12);
    qs = ack_q.size();
    check("rmr_nacks", qs, 4);
    if (qs == 4) check("rmr_madr0", ack_q[0], 32'h1230);

    // Randomised traffic against the model
    rand_mode = 1; spurious = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge w_clk); #1;
      if (!w_req || seen_rdy) begin
        if ($urandom_range(0, 3) != 0) begin
          w_req = 1'b1;
          w_adr = rand_addr();
        end else begin
          w_req = 1'b0;
        end
      end
      w_flush = ($urandom_range(0, 79) == 0);
      w_rst   = ($urandom_range(0, 299) == 0);
    end
    @(posedge w_clk); #1;
    w_req = 1'b0; w_flush = 1'b0; w_rst = 1'b0; spurious = 0;
    repeat (60) @(posedge w_clk);
    @(negedge w_clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
